i2s_fifo_reader: RTL



---
 rtl/audio_pkg.sv | 14 +
 rtl/i2s_clkgen.sv | 41 ++++
 rtl/i2s_fifo_reader.sv | 84 ++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample/gain constants, fetch FSM states and the gain-scaling helper
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int GAIN_W = 8;
  localparam int GAIN_UNITY = 128;
  typedef enum logic [1:0] {IDLE, RD, WAIT, LATCH} fetch_state_t;
  function automatic logic signed [31:0] sat_scale(input logic signed [31:0] s, input logic [GAIN_W-1:0] g, input int w);
    logic signed [40:0] p, hi, lo;
    p = (41'(s) * $signed({33'd0, g})) >>> $clog2(GAIN_UNITY);
    hi = (41'sd1 <<< (w - 1)) - 41'sd1;
    lo = -(hi + 41'sd1);
    return 32'((p > hi) ? hi : (p < lo) ? lo : p);
  endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: BCLK divider and frame bit counter; in clk/rst/enable, out bclk/lrclk plus tick, frame_start, half_start strobes
module i2s_clkgen #(
  parameter int WIDTH = 16,
  parameter int BCLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bclk,
  output logic lrclk,
  output logic tick,
  output logic frame_start,
  output logic half_start
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(2 * WIDTH);
  localparam logic [BW-1:0] LAST = BW'(2 * WIDTH - 1);
  logic [DW-1:0] div;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic wrap;
  assign wrap = div == DW'(BCLK_DIV - 1);
  assign tick = enable & wrap & bclk;
  assign bit_nxt = (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
  assign frame_start = tick & (bit_nxt == '0);
  assign half_start = tick & (bit_nxt == BW'(WIDTH));
  assign lrclk = (bit_cnt >= BW'(WIDTH - 1)) && (bit_cnt != LAST);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div <= '0;
      bclk <= 1'b0;
      bit_cnt <= LAST;
    end else if (!enable) begin
      div <= '0;
      bclk <= 1'b0;
      bit_cnt <= LAST;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      bclk <= wrap ? ~bclk : bclk;
      bit_cnt <= tick ? bit_nxt : bit_cnt;
    end
endmodule

// File: rtl/i2s_fifo_reader.sv
// i2s_fifo_reader: pops one FIFO sample per frame, applies Q1.7 gain with saturation, sends it on both I2S slots; ports: fifo_* handshake in, bclk/lrclk/sdata out, underrun pulse/count out
module i2s_fifo_reader
  import audio_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int BCLK_DIV = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [GAIN_W-1:0] gain,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [WIDTH-1:0]  fifo_dout,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_cnt
);
  fetch_state_t state, state_nxt;
  logic tick, frame_start, half_start, en_d, fetch_go;
  logic [WIDTH-1:0] next_sample, cur_sample, shift;
  i2s_clkgen #(.WIDTH(WIDTH), .BCLK_DIV(BCLK_DIV)) u_clkgen (
    .clk(clk), .rst(rst), .enable(enable), .bclk(bclk), .lrclk(lrclk),
    .tick(tick), .frame_start(frame_start), .half_start(half_start)
  );
  // fetch for the next frame at the start of the right slot, or immediately when playback starts
  assign fetch_go = half_start | (enable & ~en_d);
  always_comb begin
    state_nxt = state;
    fifo_rd = 1'b0;
    underrun = 1'b0;
    if (!enable) state_nxt = IDLE;
    else
      case (state)
        IDLE: state_nxt = fetch_go ? RD : IDLE;
        RD: begin
          fifo_rd = ~fifo_empty;
          underrun = fifo_empty;
          state_nxt = fifo_empty ? IDLE : WAIT;
        end
        WAIT: state_nxt = LATCH;
        default: state_nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      en_d <= 1'b0;
    end else begin
      state <= state_nxt;
      en_d <= enable;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      next_sample <= '0;
      underrun_cnt <= '0;
    end else if (underrun) begin
      next_sample <= '0;
      underrun_cnt <= &underrun_cnt ? underrun_cnt : underrun_cnt + 1'b1;
    end else if (enable && state == LATCH) begin
      next_sample <= WIDTH'(sat_scale(32'($signed(fifo_dout)), gain, WIDTH));
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur_sample <= '0;
      shift <= '0;
      sdata <= 1'b0;
    end else if (!enable) begin
      sdata <= 1'b0;
    end else if (frame_start) begin
      cur_sample <= next_sample;
      shift <= next_sample;
      sdata <= next_sample[WIDTH-1];
    end else if (half_start) begin
      shift <= cur_sample;
      sdata <= cur_sample[WIDTH-1];
    end else if (tick) begin
      shift <= {shift[WIDTH-2:0], 1'b0};
      sdata <= shift[WIDTH-2];
    end
endmodule
